vga_fb_scanout: RTL and testbench
=================================

// Module: vga_fb_scanout
// PURPOSE
//  Frame-buffer sink for the plot stream produced by the drawing engines (circle/line/clear FSMs).
//  Accepts one pixel write per clock (x, y, colour, plot strobe) into a W x H x CW on-chip RAM.
//  On request, streams the whole frame back out in raster order over a valid/ready pixel interface,
//  for display, readback or checking.
// PARAMETERS
//  W      160  frame width in pixels (x range 0..W-1)
//  H      120  frame height in pixels (y range 0..H-1)
//  CW     3    colour width in bits
// PORTS
//  clk        in   1   single clock, all logic rising-edge
//  rstn       in   1   asynchronous, active-low reset
//  vga_x      in   8   write x coordinate
//  vga_y      in   7   write y coordinate
//  vga_colour in   CW  write colour
//  vga_plot   in   1   write strobe; one pixel written per cycle while high
//  frame_req  in   1   pulse: start a raster readout (ignored while busy)
//  busy       out  1   readout in progress
//  px_colour  out  CW  readout pixel colour
//  px_valid   out  1   px_colour/px_sol/px_eof valid
//  px_ready   in   1   sink accepts pixel when px_valid & px_ready
//  px_sol     out  1   current pixel has x==0 (start of line)
//  px_eof     out  1   current pixel is (W-1,H-1), last of frame
//  clip_err   out  1   sticky: a plot with x>=W or y>=H was dropped; cleared by frame_req
// BEHAVIOUR
//  Reset: busy=0, px_valid=0, px_colour=0, px_sol=0, px_eof=0, clip_err=0; read counters and
//   FIFO cleared. RAM contents are NOT reset (undefined until written).
//  Write: addr = vga_y*W + vga_x (15 bits; for W=160 use (y<<7)+(y<<5)+x, no multiplier).
//   Written at the clk edge where vga_plot=1 and coordinates are in range; no back-pressure.
//   Out-of-range plot: RAM unchanged, clip_err<=1 on that edge.
//  RAM: one write port, one synchronous read port, read latency 1 cycle.
//  Readout FSM: IDLE -> RUN -> DRAIN -> IDLE.
//   IDLE: frame_req=1 -> RUN, busy<=1, rd_x=rd_y=0, clip_err<=0.
//   RUN: issue a read when (fifo_count + inflight) < 2; increment rd_x, wrap to 0 at W-1 and
//    increment rd_y; after issuing (W-1,H-1) -> DRAIN.
//   DRAIN: wait until FIFO empty and no read inflight -> IDLE, busy<=0 the cycle after the
//    px_eof pixel is accepted.
//  Output: 2-entry FIFO with px_sol/px_eof tagged per entry. px_valid = FIFO not empty.
//   Head pops on px_valid & px_ready; outputs held stable while px_valid & !px_ready.
//   With px_ready held 1, first px_valid is 2 cycles after frame_req; then 1 pixel/cycle,
//   W*H pixels total.
//  frame_req while busy: ignored; clip_err not cleared.
//  Write during readout: allowed. A pixel reflects a write whose edge precedes its read-issue
//   cycle. Write and read of the same address in the same cycle: see FB_BYPASS_EN.
//  Reset mid-readout: immediate return to IDLE, FIFO flushed, px_valid=0. RAM retains data.
// CONFIGURATION
//  FB_BYPASS_EN defined: same-cycle write/read to the same address returns the NEW colour
//   (write data forwarded into the read pipeline).
//  FB_BYPASS_EN undefined: the read returns the OLD RAM contents; no forwarding logic.
// TESTING
//  1 Reset: rstn=0 mid-stream -> all outputs 0, busy=0; after release frame_req restarts cleanly.
//  2 Fill frame with colour=(x+y)%8, frame_req, px_ready=1 -> 19200 pixels in raster order,
//    px_sol on every 160th, px_eof only on the last, busy low 1 cycle after.
//  3 Plot (80,60)=5, (159,119)=3, (0,0)=7 over cleared frame -> those values at pixel indices
//    9680, 19199, 0; all others 0.
//  4 Random px_ready (50%) -> same sequence as scenario 2, no drop or duplicate;
//    px_colour stable while stalled.
//  5 Plot (160,0) and (0,120) -> RAM unchanged, clip_err=1; next frame_req clears it.
//  6 During readout, write (10,0)=6 in the same cycle its read issues -> pixel 10 reads 6 with
//    FB_BYPASS_EN, old value without it; frame_req while busy is ignored.

Source files
------------

// File: rtl/vga_fb_if.sv
// vga_fb_if: signal bundle between the drawing side / display sink and vga_fb_scanout.
//   master: plot writes (vga_x, vga_y, vga_colour, vga_plot), frame_req, px_ready
//   slave : busy, clip_err and the pixel stream (px_colour, px_valid, px_sol, px_eof)
interface vga_fb_if #(
    parameter int CW = 3
);
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;
    logic          frame_req;
    logic          busy;
    logic [CW-1:0] px_colour;
    logic          px_valid;
    logic          px_ready;
    logic          px_sol;
    logic          px_eof;
    logic          clip_err;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, frame_req, px_ready,
        input  busy, px_colour, px_valid, px_sol, px_eof, clip_err
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, frame_req, px_ready,
        output busy, px_colour, px_valid, px_sol, px_eof, clip_err
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: W x H x CW frame buffer fed by plot strobes, streamed back in raster order.
//   clk  : single rising-edge clock
//   rstn : asynchronous active-low reset (RAM contents are kept)
//   bus  : vga_fb_if.slave -- plot write port, frame_req/busy/clip_err, px_* valid/ready stream
// Build option FB_BYPASS_EN: a write and a read of the same address on the same edge return
// the new colour; without it the read returns the old RAM contents.
module vga_fb_scanout #(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int CW = 3
) (
    input logic     clk,
    input logic     rstn,
    vga_fb_if.slave bus
);
    localparam int AW = 15;
    localparam logic [7:0] XMAX = 8'(W - 1);
    localparam logic [6:0] YMAX = 7'(H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_mem [W*H];
    logic [CW-1:0] r_rd_data;
    logic [7:0]    r_rd_x;
    logic [6:0]    r_rd_y;
    logic          r_inflight, r_inf_sol, r_inf_eof;
    logic [CW-1:0] r_fifo_col [2];
    logic [1:0]    r_fifo_sol, r_fifo_eof;
    logic          r_wp, r_rp;
    logic [1:0]    r_cnt;
    logic          r_clip_err;
    logic          w_in_range, w_wr_en, w_start, w_valid, w_pop, w_issue, w_last;
    logic [AW-1:0] w_wr_addr, w_rd_addr;

    function automatic logic [AW-1:0] addr(input logic [7:0] x, input logic [6:0] y);
        return (W == 160) ? (AW'(y) << 7) + (AW'(y) << 5) + AW'(x) : AW'(y) * AW'(W) + AW'(x);
    endfunction

    assign w_in_range = (bus.vga_x <= XMAX) && (bus.vga_y <= YMAX);
    assign w_wr_en    = bus.vga_plot && w_in_range;
    assign w_wr_addr  = addr(bus.vga_x, bus.vga_y);
    assign w_rd_addr  = addr(r_rd_x, r_rd_y);
    assign w_start    = (r_state == IDLE) && bus.frame_req;
    assign w_valid    = r_cnt != 2'd0;
    assign w_pop      = w_valid && bus.px_ready;
    assign w_last     = (r_rd_x == XMAX) && (r_rd_y == YMAX);
    // Counting this cycle's pop lets a read issue into the slot being freed, so a
    // 2-entry FIFO sustains one pixel per cycle without ever overflowing.
    assign w_issue    = (r_state == RUN) && ((r_cnt + {1'b0, r_inflight}) < (2'd2 + {1'b0, w_pop}));

    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = RUN;
        else if (w_issue && w_last)
            w_next = DRAIN;
        else if ((r_state == DRAIN) && !w_valid && !r_inflight)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= bus.vga_colour;
        if (w_issue)
`ifdef FB_BYPASS_EN
            r_rd_data <= (w_wr_en && (w_wr_addr == w_rd_addr)) ? bus.vga_colour : r_mem[w_rd_addr];
`else
            r_rd_data <= r_mem[w_rd_addr];
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_rd_x        <= '0;
            r_rd_y        <= '0;
            r_inflight    <= 1'b0;
            r_inf_sol     <= 1'b0;
            r_inf_eof     <= 1'b0;
            r_fifo_col[0] <= '0;
            r_fifo_col[1] <= '0;
            r_fifo_sol    <= '0;
            r_fifo_eof    <= '0;
            r_wp          <= 1'b0;
            r_rp          <= 1'b0;
            r_cnt         <= '0;
            r_clip_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_rd_x <= '0;
                r_rd_y <= '0;
            end else if (w_issue) begin
                r_rd_x <= (r_rd_x == XMAX) ? '0 : r_rd_x + 8'd1;
                if (r_rd_x == XMAX)
                    r_rd_y <= r_rd_y + 7'd1;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_sol <= r_rd_x == '0;
                r_inf_eof <= w_last;
            end
            if (r_inflight) begin
                r_fifo_col[r_wp] <= r_rd_data;
                r_fifo_sol[r_wp] <= r_inf_sol;
                r_fifo_eof[r_wp] <= r_inf_eof;
                r_wp             <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
            r_clip_err <= (bus.vga_plot && !w_in_range) || (r_clip_err && !w_start);
        end
    end

    assign bus.busy      = r_state != IDLE;
    assign bus.px_valid  = w_valid;
    assign bus.px_colour = r_fifo_col[r_rp];
    assign bus.px_sol    = w_valid && r_fifo_sol[r_rp];
    assign bus.px_eof    = w_valid && r_fifo_eof[r_rp];
    assign bus.clip_err  = r_clip_err;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: scoreboard bench for vga_fb_scanout (expected pixels queued at stimulus,
// popped and compared by a negedge monitor on every accepted pixel).
module tb_vga_fb_scanout;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    typedef struct packed {
        logic [2:0] col;
        logic       sol;
        logic       eof;
    } px_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   passes = 0;
    int   n_acc = 0;
    int   eof_cyc = -1;
    int   c0 = 0;
    int   n0 = 0;
    bit   rnd_ready = 1'b0;
    bit   hold = 1'b0;
    px_t  exp_q[$];
    px_t  held, got, e;
    logic [2:0] p10;

    vga_fb_if #(.CW(3)) bus ();

    vga_fb_scanout #(.W(W), .H(H), .CW(3)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        if (rnd_ready)
            bus.px_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act == req)
            passes++;
        else
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    always @(negedge clk) begin
        got = {bus.px_colour, bus.px_sol, bus.px_eof};
        if (!rstn) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", int'(bus.px_valid), 1);
                check("stall_hold", int'(got), int'(held));
            end
            hold = bus.px_valid && !bus.px_ready;
            held = got;
            if (bus.px_valid && bus.px_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_px: pixel #%0d arrived, none expected", n_acc);
                end else begin
                    e = exp_q.pop_front();
                    if (got == e)
                        passes++;
                    else
                        $display("FAIL px #%0d: got col=%0d sol=%0d eof=%0d, expected col=%0d sol=%0d eof=%0d",
                                 n_acc, got.col, got.sol, got.eof, e.col, e.sol, e.eof);
                end
                n_acc++;
                if (got.eof) begin
                    eof_cyc = cyc;
                    @(negedge clk);
                    check("busy_after_eof", int'(bus.busy), 1);
                    check("valid_after_eof", int'(bus.px_valid), 0);
                    @(negedge clk);
                    check("busy_low", int'(bus.busy), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        bus.vga_x      = 8'(x);
        bus.vga_y      = 7'(y);
        bus.vga_colour = 3'(c);
        bus.vga_plot   = 1'b1;
        tick();
        bus.vga_plot   = 1'b0;
    endtask

    task automatic push_pattern(input logic [2:0] pix10);
        for (int i = 0; i < N; i++)
            exp_q.push_back('{col: (i == 10) ? pix10 : 3'((i % W + i / W) % 8),
                              sol: (i % W) == 0, eof: i == N - 1});
    endtask

    task automatic push_sparse();
        for (int i = 0; i < N; i++)
            exp_q.push_back('{col: (i == 0) ? 3'd7 : (i == 9680) ? 3'd5 : (i == N - 1) ? 3'd3 : 3'd0,
                              sol: (i % W) == 0, eof: i == N - 1});
    endtask

    task automatic start_frame();
        eof_cyc       = -1;
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        c0            = cyc;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (eof_cyc < 0 && t < budget) begin
            tick();
            t++;
        end
        check("frame_done", int'(eof_cyc >= 0), 1);
        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_busy"}, int'(bus.busy), 0);
        check({nm, "_valid"}, int'(bus.px_valid), 0);
        check({nm, "_colour"}, int'(bus.px_colour), 0);
        check({nm, "_sol"}, int'(bus.px_sol), 0);
        check({nm, "_eof"}, int'(bus.px_eof), 0);
        check({nm, "_clip"}, int'(bus.clip_err), 0);
    endtask

    initial begin
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        bus.frame_req  = 1'b0;
        bus.px_ready   = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rstn = 1'b1;
        tick();

        // Fill with (x+y)%8
        for (int i = 0; i < N; i++) begin
            bus.vga_x      = 8'(i % W);
            bus.vga_y      = 7'(i / W);
            bus.vga_colour = 3'((i % W + i / W) % 8);
            bus.vga_plot   = 1'b1;
            tick();
        end
        bus.vga_plot = 1'b0;

        // Frame A: ready held high; (10,0)=6 written on the edge pixel 10 is read,
        // then the frame is cleared a fixed distance behind the read pointer.
`ifdef FB_BYPASS_EN
        p10 = 3'd6;
`else
        p10 = 3'd2;
`endif
        push_pattern(p10);
        start_frame();
        check("busy_on_req", int'(bus.busy), 1);
        for (int k = 1; k <= N + 11; k++) begin
            bus.frame_req = (k == 100);
            bus.vga_plot  = 1'b1;
            if (k == 11) begin
                bus.vga_x      = 8'd10;
                bus.vga_y      = 7'd0;
                bus.vga_colour = 3'd6;
            end else if (k >= 12) begin
                bus.vga_x      = 8'((k - 12) % W);
                bus.vga_y      = 7'((k - 12) / W);
                bus.vga_colour = 3'd0;
            end else begin
                bus.vga_plot = 1'b0;
            end
            tick();
            if (k == 1) check("first_valid_early", int'(bus.px_valid), 0);
            if (k == 2) check("first_valid", int'(bus.px_valid), 1);
        end
        bus.vga_plot  = 1'b0;
        bus.frame_req = 1'b0;
        wait_done(10);
        check("throughput", eof_cyc - c0, N + 1);

        // Clipped plots, then sparse picture
        check("clip_idle", int'(bus.clip_err), 0);
        plot(160, 0, 5);
        check("clip_x", int'(bus.clip_err), 1);
        plot(0, 120, 6);
        check("clip_y", int'(bus.clip_err), 1);
        plot(80, 60, 5);
        plot(159, 119, 3);
        plot(0, 0, 7);
        check("clip_sticky", int'(bus.clip_err), 1);

        // Frame B: random back-pressure over the sparse picture
        push_sparse();
        rnd_ready = 1'b1;
        start_frame();
        check("clip_cleared", int'(bus.clip_err), 0);
        repeat (5) tick();
        plot(0, 120, 1);
        check("clip_busy_set", int'(bus.clip_err), 1);
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        check("clip_kept", int'(bus.clip_err), 1);
        check("busy_kept", int'(bus.busy), 1);
        wait_done(4 * N);
        rnd_ready = 1'b0;
        tick();
        bus.px_ready = 1'b1;

        // Frame C: reset mid-stream, then restart
        push_sparse();
        start_frame();
        repeat (20) tick();
        plot(200, 5, 1);
        repeat (30) tick();
        check("clip_pre_reset", int'(bus.clip_err), 1);
        rstn = 1'b0;
        #2;
        exp_q.delete();
        check_idle_outputs("mid_reset");
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        check("post_reset_valid", int'(bus.px_valid), 0);
        check("post_reset_busy", int'(bus.busy), 0);
        push_sparse();
        n0 = n_acc;
        start_frame();
        repeat (40) tick();
        check("restart_count", n_acc - n0, 38);
        check("restart_busy", int'(bus.busy), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
